md_ctrl: RTL

Multi-cycle multiply/divide controller for the five-stage MIPS pipeline, sitting beside the ALU in the E stage. It accepts one HI/LO-class operation per cycle from the E stage and sequences MULT/DIV through a fixed-latency busy window. It owns the HI/LO registers and raises a stall request that the stall unit ORs into its pipeline stall. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/md_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide sequencer owning HI/LO, with a fixed-latency busy window.
// Define MD_CTRL_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_md,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [3:0] OP_NONE  = 4'd0,  OP_MULT  = 4'd1,  OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3,  OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6,  OP_MFHI  = 4'd7,  OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic               busy_q, busy_d;

  logic               is_mul_op, is_div_op;
  logic               mul_signed, div_signed, a_neg, b_neg;
  logic [63:0]        a_ext, b_ext, product, mul_result;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    is_mul_op = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
`ifdef MD_CTRL_MADD_EN
    is_mul_op = is_mul_op || (E_md_op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`endif
    is_div_op = (E_md_op == OP_DIV) || (E_md_op == OP_DIVU);
  end

  assign start    = (is_mul_op || is_div_op) && (state_q == ST_IDLE);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = D_md & (start | busy_q);
  assign md_out   = (E_md_op == OP_MFHI) ? hi_q :
                    (E_md_op == OP_MFLO) ? lo_q : 32'd0;

  // Datapath works only from the latched operands so E-stage churn during busy is harmless.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product    = a_ext * b_ext;
    mul_result = product;
`ifdef MD_CTRL_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU)
      mul_result = {hi_q, lo_q} + product;
    else if (op_q == OP_MSUB || op_q == OP_MSUBU)
      mul_result = {hi_q, lo_q} - product;
`endif
    // Sign-magnitude divide sidesteps the 0x80000000 / -1 overflow corner.
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    q_mag      = a_mag / b_mag;
    r_mag      = a_mag % b_mag;
    quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = E_rs_val;
          b_d     = E_rt_val;
          op_d    = E_md_op;
          cnt_d   = is_div_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d = is_div_op ? ST_DIV : ST_MUL;
        end else if (E_md_op == OP_MTHI) begin
          hi_d = E_rs_val;
        end else if (E_md_op == OP_MTLO) begin
          lo_d = E_rs_val;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          if (state_q == ST_MUL) begin
            {hi_d, lo_d} = mul_result;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
    end
  end

endmodule
